// File: rtl/pe_group_ctrl_if.sv
// Control/status bundle between the pass sequencer and its requester/pe_group.
// The master side issues pass requests and ifmap availability; the slave side is the controller.
interface pe_group_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [3:0]       layer;
    logic [CNT_W-1:0] out_width;
    logic [CNT_W-1:0] num_rows;
    logic             ifmap_valid;
    logic             weight_en;
    logic [2:0]       weight_sel;
    logic             ifmap_rd_en;
    logic             calculate_en;
    logic [3:0]       layer_out;
    logic             psum_valid;
    logic             psum_last;
    logic             busy;
    logic             done;

    modport master (
        output start, layer, out_width, num_rows, ifmap_valid,
        input  weight_en, weight_sel, ifmap_rd_en, calculate_en,
               layer_out, psum_valid, psum_last, busy, done
    );

    modport slave (
        input  start, layer, out_width, num_rows, ifmap_valid,
        output weight_en, weight_sel, ifmap_rd_en, calculate_en,
               layer_out, psum_valid, psum_last, busy, done
    );
endinterface

// File: rtl/pe_group_ctrl.sv
// Pass sequencer for a pe_group: loads weights, streams out_width*num_rows ifmap vectors,
// drains the pipeline and flags which pipeline outputs carry real partial sums.
module pe_group_ctrl #(
    parameter int KSIZE    = 5,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    pe_group_ctrl_if.slave  bus
);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [2:0]         WSEL_LAST  = 3'(KSIZE - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           wsel_reg, wsel_next;
    logic [CNT_W-1:0]     col_reg, col_next;
    logic [CNT_W-1:0]     row_reg, row_next;
    logic [DRAIN_W-1:0]   drain_reg, drain_next;
    logic [3:0]           layer_reg;
    logic [CNT_W-1:0]     width_reg, rows_reg;
    logic [PIPE_LAT-1:0]  tag_reg, last_reg;
    logic [PIPE_LAT-1:0]  tag_shift, last_shift;
    logic                 accept, weight_en, calc, rd_en, shift_in, last_in, at_last;

    assign at_last = (col_reg == width_reg - 1'b1) && (row_reg == rows_reg - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            wsel_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            drain_reg <= '0;
            layer_reg <= '0;
            width_reg <= '0;
            rows_reg  <= '0;
            tag_reg   <= '0;
            last_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wsel_reg  <= wsel_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            drain_reg <= drain_next;
            if (accept) begin
                layer_reg <= bus.layer;
                width_reg <= bus.out_width;
                rows_reg  <= bus.num_rows;
            end
            if (calc) begin
                tag_reg  <= tag_shift;
                last_reg <= last_shift;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wsel_next  = wsel_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        drain_next = drain_reg;
        accept     = 1'b0;
        weight_en  = 1'b0;
        calc       = 1'b0;
        rd_en      = 1'b0;
        shift_in   = 1'b0;
        last_in    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.out_width != '0 && bus.num_rows != '0) begin
                        state_next = LOAD_W;
                        wsel_next  = '0;
                        col_next   = '0;
                        row_next   = '0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LOAD_W: begin
                weight_en = 1'b1;
                if (wsel_reg == WSEL_LAST) begin
                    state_next = STREAM;
                end else begin
                    wsel_next = wsel_reg + 3'd1;
                end
            end
            STREAM: begin
                if (bus.ifmap_valid) begin
                    calc     = 1'b1;
                    rd_en    = 1'b1;
                    shift_in = 1'b1;
                    last_in  = at_last;
                    if (at_last) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end else if (col_reg == width_reg - 1'b1) begin
                        col_next = '0;
                        row_next = row_reg + 1'b1;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                calc = 1'b1;
                if (drain_reg == DRAIN_LAST) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Tag/last shift chains mirror the pe_group stages; they advance only with calculate_en.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_shift[0]  = shift_in;
                assign last_shift[0] = last_in;
            end else begin : g_body
                assign tag_shift[gi]  = tag_reg[gi-1];
                assign last_shift[gi] = last_reg[gi-1];
            end
        end
    endgenerate

    // Qualified by calculate_en so a result held during a stall is reported exactly once.
    assign bus.psum_valid   = tag_reg[PIPE_LAT-1] & calc;
    assign bus.psum_last    = last_reg[PIPE_LAT-1] & calc;
    assign bus.weight_en    = weight_en;
    assign bus.weight_sel   = weight_en ? wsel_reg : 3'd0;
    assign bus.ifmap_rd_en  = rd_en;
    assign bus.calculate_en = calc;
    assign bus.layer_out    = layer_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.done         = (state_reg == DONE);
endmodule

// File: tb/tb_pe_group_ctrl.sv
// Directed bench for pe_group_ctrl: nominal, stalled, zero-size, re-start, reset-abort
// and maximum-width passes, with hand-computed counts and latencies.
module tb_pe_group_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pe_group_ctrl_if #(.CNT_W(8)) bus ();

    pe_group_ctrl #(.KSIZE(5), .PIPE_LAT(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cnt_we, cnt_cs, cnt_cd, cnt_pv, cnt_last, cnt_done, cnt_overlap, last_at;
    logic [14:0] sel_hist;

    initial begin
        cnt_we = 0; cnt_cs = 0; cnt_cd = 0; cnt_pv = 0; cnt_last = 0;
        cnt_done = 0; cnt_overlap = 0; last_at = 0; sel_hist = '0;
    end

    always @(negedge clk) begin
        if (bus.weight_en) begin
            cnt_we++;
            sel_hist = {sel_hist[11:0], bus.weight_sel};
        end
        if (bus.calculate_en && bus.ifmap_rd_en) cnt_cs++;
        if (bus.calculate_en && !bus.ifmap_rd_en) cnt_cd++;
        if (bus.psum_valid) cnt_pv++;
        if (bus.psum_last) begin
            cnt_last++;
            last_at = cnt_pv;
        end
        if (bus.done) cnt_done++;
        if (bus.weight_en && bus.calculate_en) cnt_overlap++;
    end

    int we0, cs0, cd0, pv0, lst0, dn0;

    task automatic snap();
        we0 = cnt_we; cs0 = cnt_cs; cd0 = cnt_cd;
        pv0 = cnt_pv; lst0 = cnt_last; dn0 = cnt_done;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input logic [3:0] ly, input logic [7:0] w, input logic [7:0] r);
        bus.layer       = ly;
        bus.out_width   = w;
        bus.num_rows    = r;
        bus.ifmap_valid = 1'b1;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
    endtask

    // Cycle 0 is the first cycle after the accepting edge; stops at the DONE cycle,
    // on a reset injection at cycle rc, or when the bound expires.
    task automatic run_pass(input int sa, input int sb, input int rp, input int rc,
                            output int cyc, output logic stall_calc, output logic aborted,
                            output logic timed_out);
        cyc = 0; stall_calc = 1'b0; aborted = 1'b0; timed_out = 1'b1;
        while (cyc < 2000) begin
            bus.ifmap_valid = !(cyc == sa || cyc == sb);
            if (cyc == rp) begin
                bus.start = 1'b1; bus.layer = 4'd7; bus.out_width = 8'd9; bus.num_rows = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == rc) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                aborted = 1'b1;
                timed_out = 1'b0;
                break;
            end
            #1;
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            if (cyc == sa) stall_calc = bus.calculate_en;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.ifmap_valid = 1'b1;
    endtask

    task automatic finish_pass(input string name);
        @(posedge clk); #1;
        check({name, "_idle_busy"}, 32'(bus.busy), 0);
        check({name, "_done_pulses"}, 32'(cnt_done - dn0), 1);
    endtask

    int   cyc;
    logic stall_calc, aborted, timed_out;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.layer = '0; bus.out_width = '0; bus.num_rows = '0;
        bus.ifmap_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(bus.busy), 0);
        check("rst_outputs",  32'({bus.weight_en, bus.weight_sel, bus.ifmap_rd_en, bus.calculate_en,
                                   bus.psum_valid, bus.psum_last, bus.done}), 0);
        check("rst_layer",    32'(bus.layer_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal 4x2 pass
        snap();
        start_pass(4'd1, 8'd4, 8'd2);
        check("nom_busy_load", 32'(bus.busy), 1);
        check("nom_we_first",  32'(bus.weight_en), 1);
        run_pass(-1, -1, -1, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass nominal: done_cycle=%0d we=%0d calc=%0d/%0d pv=%0d", cyc,
                 cnt_we - we0, cnt_cs - cs0, cnt_cd - cd0, cnt_pv - pv0);
        check("nom_timeout",   32'(timed_out), 0);
        check("nom_done_cyc",  32'(cyc), 16);
        check("nom_we",        32'(cnt_we - we0), 5);
        check("nom_sel_seq",   32'(sel_hist), 32'(15'o01234));
        check("nom_calc_str",  32'(cnt_cs - cs0), 8);
        check("nom_calc_drn",  32'(cnt_cd - cd0), 3);
        check("nom_pv",        32'(cnt_pv - pv0), 8);
        check("nom_last_cnt",  32'(cnt_last - lst0), 1);
        check("nom_last_idx",  32'(last_at - pv0), 8);
        check("nom_layer",     32'(bus.layer_out), 1);
        finish_pass("nom");

        // Stalls on STREAM cycles 2 and 5 (absolute cycles 7 and 10)
        snap();
        start_pass(4'd1, 8'd4, 8'd2);
        run_pass(7, 10, -1, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass stall: done_cycle=%0d pv=%0d", cyc, cnt_pv - pv0);
        check("stl_timeout",   32'(timed_out), 0);
        check("stl_calc_low",  32'(stall_calc), 0);
        check("stl_done_cyc",  32'(cyc), 18);
        check("stl_calc_str",  32'(cnt_cs - cs0), 8);
        check("stl_pv",        32'(cnt_pv - pv0), 8);
        check("stl_last_idx",  32'(last_at - pv0), 8);
        finish_pass("stl");

        // Zero width goes straight to DONE
        snap();
        start_pass(4'd2, 8'd0, 8'd3);
        run_pass(-1, -1, -1, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass zero: done_cycle=%0d we=%0d calc=%0d pv=%0d", cyc,
                 cnt_we - we0, cnt_cs - cs0 + cnt_cd - cd0, cnt_pv - pv0);
        check("zero_done_cyc", 32'(cyc), 0);
        check("zero_busy",     32'(bus.busy), 1);
        check("zero_we",       32'(cnt_we - we0), 0);
        check("zero_calc",     32'(cnt_cs - cs0 + cnt_cd - cd0), 0);
        check("zero_pv",       32'(cnt_pv - pv0), 0);
        finish_pass("zero");

        // Re-start with layer 7 during STREAM is ignored
        snap();
        start_pass(4'd1, 8'd4, 8'd2);
        run_pass(-1, -1, 8, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass restart: done_cycle=%0d layer_out=%0d pv=%0d", cyc, bus.layer_out, cnt_pv - pv0);
        check("rep_done_cyc",  32'(cyc), 16);
        check("rep_layer",     32'(bus.layer_out), 1);
        check("rep_pv",        32'(cnt_pv - pv0), 8);
        finish_pass("rep");

        // Reset during second DRAIN cycle (cycle 14)
        snap();
        start_pass(4'd3, 8'd4, 8'd2);
        run_pass(-1, -1, -1, 14, cyc, stall_calc, aborted, timed_out);
        check("rab_aborted",   32'(aborted), 1);
        check("rab_busy",      32'(bus.busy), 0);
        check("rab_pv",        32'(bus.psum_valid), 0);
        check("rab_outputs",   32'({bus.weight_en, bus.calculate_en, bus.psum_last, bus.done}), 0);
        check("rab_layer",     32'(bus.layer_out), 0);
        repeat (6) @(posedge clk);
        #1;
        $display("pass reset-abort: pv=%0d done=%0d", cnt_pv - pv0, cnt_done - dn0);
        check("rab_pv_total",  32'(cnt_pv - pv0), 7);
        check("rab_no_last",   32'(cnt_last - lst0), 0);
        check("rab_no_done",   32'(cnt_done - dn0), 0);
        snap();
        start_pass(4'd1, 8'd4, 8'd2);
        run_pass(-1, -1, -1, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass post-reset: done_cycle=%0d pv=%0d", cyc, cnt_pv - pv0);
        check("prs_done_cyc",  32'(cyc), 16);
        check("prs_pv",        32'(cnt_pv - pv0), 8);
        check("prs_last_idx",  32'(last_at - pv0), 8);
        finish_pass("prs");

        // Maximum width 255x1
        snap();
        start_pass(4'd4, 8'd255, 8'd1);
        run_pass(-1, -1, -1, -1, cyc, stall_calc, aborted, timed_out);
        $display("pass max: done_cycle=%0d pv=%0d last_idx=%0d", cyc, cnt_pv - pv0, last_at - pv0);
        check("max_timeout",   32'(timed_out), 0);
        check("max_done_cyc",  32'(cyc), 263);
        check("max_calc_str",  32'(cnt_cs - cs0), 255);
        check("max_pv",        32'(cnt_pv - pv0), 255);
        check("max_last_cnt",  32'(cnt_last - lst0), 1);
        check("max_last_idx",  32'(last_at - pv0), 255);
        finish_pass("max");

        check("we_calc_overlap", 32'(cnt_overlap), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
